int32_to_fp32: RTL and testbench

Pipelined signed 32-bit integer to IEEE-754 single-precision converter with a go/done trigger, the inverse of the FP-to-int conversion unit in the floating-point operator library. It is written in plain synthesizable RTL with no vendor core. It converts one operand per cycle with a fixed 4-cycle latency. It sits beside the other multi-cycle primitives and is driven by the same trigger-style scheduling logic.

---
 rtl/int32_to_fp32.sv | 99 +++++++++
 tb/tb_int32_to_fp32.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/int32_to_fp32.sv
// Signed 32-bit integer to IEEE-754 binary32 converter with a fixed 4-edge latency.
// Round to nearest, ties to even; zero always converts to positive zero.
module int32_to_fp32 (
    input  logic        clock,
    input  logic        reset,
    input  logic        in_0,
    input  logic [31:0] in_1,
    output logic        out_0,
    output logic [31:0] out_1
);

    localparam int DATA_W = 32;

    // Leading-zero count; returns 32 for an all-zero operand.
    function automatic logic [5:0] lzc32(input logic [DATA_W-1:0] v);
        logic [5:0] n;
        logic       found;
        n     = 6'd32;
        found = 1'b0;
        for (int i = DATA_W - 1; i >= 0; i--) begin
            if (!found && v[i]) begin
                n     = 6'(DATA_W - 1 - i);
                found = 1'b1;
            end
        end
        return n;
    endfunction

    // Round-to-nearest-even on the normalised magnitude; a mantissa carry
    // ripples naturally into the exponent field.
    function automatic logic [31:0] round_pack(input logic s, input logic z,
                                               input logic [7:0] e,
                                               input logic [30:0] n);
        logic        inc;
        logic [30:0] em;
        inc = n[7] & ((|n[6:0]) | n[8]);
        em  = {e, n[30:8]} + {30'd0, inc};
        return z ? 32'd0 : {s, em};
    endfunction

    logic               vld_p0, vld_p1, vld_p2, vld_p3, vld_p4;
    logic signed [31:0] opnd_p0;
    logic               sign_p1, sign_p2, sign_p3;
    logic [31:0]        mag_p1, mag_p2;
    logic [5:0]         lz_p2;
    logic               zero_p2, zero_p3;
    logic [30:0]        norm_p3;
    logic [7:0]         exp_p3;
    logic [31:0]        res_p4;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            vld_p0  <= 1'b0;
            vld_p1  <= 1'b0;
            vld_p2  <= 1'b0;
            vld_p3  <= 1'b0;
            vld_p4  <= 1'b0;
            opnd_p0 <= '0;
            sign_p1 <= 1'b0;
            mag_p1  <= '0;
            sign_p2 <= 1'b0;
            mag_p2  <= '0;
            lz_p2   <= '0;
            zero_p2 <= 1'b0;
            sign_p3 <= 1'b0;
            zero_p3 <= 1'b0;
            norm_p3 <= '0;
            exp_p3  <= '0;
            res_p4  <= '0;
        end else begin
            // p0: operand capture
            vld_p0  <= in_0;
            opnd_p0 <= in_1;
            // p1: sign and magnitude (0x80000000 wraps to itself)
            vld_p1  <= vld_p0;
            sign_p1 <= opnd_p0[31];
            mag_p1  <= opnd_p0[31] ? 32'(-opnd_p0) : opnd_p0;
            // p2: leading-zero count
            vld_p2  <= vld_p1;
            sign_p2 <= sign_p1;
            mag_p2  <= mag_p1;
            lz_p2   <= lzc32(mag_p1);
            zero_p2 <= (mag_p1 == 32'd0);
            // p3: normalise, hidden bit at bit 31 is dropped
            vld_p3  <= vld_p2;
            sign_p3 <= sign_p2;
            zero_p3 <= zero_p2;
            norm_p3 <= 31'(mag_p2 << lz_p2);
            exp_p3  <= 8'(9'd158 - {3'd0, lz_p2});
            // p4: round and pack
            vld_p4  <= vld_p3;
            res_p4  <= round_pack(sign_p3, zero_p3, exp_p3, norm_p3);
        end
    end

    assign out_0 = vld_p4;
    assign out_1 = res_p4;

endmodule

// File: tb/tb_int32_to_fp32.sv
// Bench for int32_to_fp32: directed corner values, random streaming against an
// arithmetic reference, sparse triggers and a mid-flight reset.
module tb_int32_to_fp32;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        in_0  = 1'b0;
    logic [31:0] in_1  = 32'd0;
    logic        out_0;
    logic [31:0] out_1;

    int passed = 0;
    int total  = 0;

    // Expected-output delay line: entry 4 is what the DUT should show now.
    logic        pv[5];
    logic [31:0] pd[5];

    int32_to_fp32 dut (
        .clock(clock),
        .reset(reset),
        .in_0 (in_0),
        .in_1 (in_1),
        .out_0(out_0),
        .out_1(out_1)
    );

    always #5 clock = ~clock;

    // Reference conversion from the real value: find the exponent, divide,
    // and round the remainder against one half.
    function automatic logic [31:0] ref_cvt(input logic [31:0] x);
        longint v, m, q, r, dv;
        int     e;
        logic   s;
        v = longint'(signed'(x));
        s = (v < 0);
        m = s ? -v : v;
        if (m == 0) return 32'd0;
        e = 0;
        while ((m >> (e + 1)) != 0) e++;
        if (e <= 23) begin
            q = m << (23 - e);
        end else begin
            dv = longint'(1) << (e - 23);
            q  = m / dv;
            r  = m % dv;
            if ((r * 2 > dv) || ((r * 2 == dv) && (q % 2 == 1))) q++;
            if (q == (longint'(1) << 24)) begin
                q = q / 2;
                e++;
            end
        end
        return {s, 8'(e + 127), q[22:0]};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) begin
            passed++;
        end else begin
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < 5; i++) begin
            pv[i] = 1'b0;
            pd[i] = 32'd0;
        end
    endtask

    // One clock: drive, step the model, then compare just after the edge.
    task automatic cycle(input string tag, input logic go, input logic [31:0] d,
                         input logic [31:0] expv);
        in_0 = go;
        in_1 = d;
        @(posedge clock);
        #1;
        for (int i = 4; i > 0; i--) begin
            pv[i] = pv[i-1];
            pd[i] = pd[i-1];
        end
        pv[0] = go;
        pd[0] = expv;
        if (reset) begin
            check({tag, " out_0"}, {31'd0, out_0}, {31'd0, pv[4]});
            if (pv[4]) check({tag, " out_1"}, out_1, pd[4]);
        end else begin
            check({tag, " out_0 in reset"}, {31'd0, out_0}, 32'd0);
            check({tag, " out_1 in reset"}, out_1, 32'd0);
        end
    endtask

    task automatic idle(input string tag, input int n);
        logic [31:0] d;
        for (int i = 0; i < n; i++) begin
            d = $urandom | 32'h0000_0100;
            cycle(tag, 1'b0, d, ref_cvt(d));
        end
    endtask

    task automatic single(input string tag, input logic [31:0] d, input logic [31:0] expv);
        cycle(tag, 1'b1, d, expv);
        idle(tag, 4);
    endtask

    logic [31:0] rd;

    initial begin
        clear_model();
        #1;
        check("reset out_0", {31'd0, out_0}, 32'd0);
        check("reset out_1", out_1, 32'd0);
        idle("in_reset", 2);
        @(negedge clock);
        reset = 1'b1;
        idle("post_reset", 5);

        single("one",        32'd1,        32'h3F80_0000);
        single("minus_one",  32'hFFFF_FFFF, 32'hBF80_0000);
        single("zero",       32'd0,        32'h0000_0000);
        single("max_pos",    32'h7FFF_FFFF, 32'h4F00_0000);
        single("min_neg",    32'h8000_0000, 32'hCF00_0000);
        single("two_pow24",  32'd16777216, 32'h4B80_0000);
        single("tie_even",   32'd16777217, 32'h4B80_0000);
        single("tie_up",     32'd16777219, 32'h4B80_0002);
        single("exact_2p24", 32'd16777218, 32'h4B80_0001);
        single("neg_tie_up", -32'sd16777219, 32'hCB80_0002);

        for (int i = 0; i < 100; i++) begin
            rd = $urandom >> $urandom_range(0, 31);
            if ($urandom_range(0, 1) == 1) rd = -rd;
            cycle("stream", 1'b1, rd, ref_cvt(rd));
        end
        idle("stream_drain", 6);

        cycle("sparse", 1'b1, 32'd1000,       32'h447A_0000);
        cycle("sparse", 1'b0, 32'd7,          ref_cvt(32'd7));
        cycle("sparse", 1'b1, -32'sd3,        32'hC040_0000);
        cycle("sparse", 1'b1, 32'h0123_4567,  ref_cvt(32'h0123_4567));
        idle("sparse", 6);

        rd = $urandom | 32'h1;
        cycle("flight", 1'b1, rd, ref_cvt(rd));
        rd = $urandom | 32'h1;
        cycle("flight", 1'b1, rd, ref_cvt(rd));
        idle("flight", 1);
        reset = 1'b0;
        #1;
        check("async out_0", {31'd0, out_0}, 32'd0);
        check("async out_1", out_1, 32'd0);
        clear_model();
        idle("flight_rst", 2);
        @(negedge clock);
        reset = 1'b1;
        idle("flight_flush", 6);
        single("after_rst", 32'd42, 32'h4228_0000);

        for (int i = 0; i < 40; i++) begin
            rd = $urandom;
            cycle("mixed", 1'($urandom_range(0, 1)), rd, ref_cvt(rd));
        end
        idle("mixed_drain", 6);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
